pwm_gen_multi: RTL and testbench

- Multi-channel PWM generator: owns the period counter, per-channel compare and output polarity.
- Adds double-buffered (shadow) period/duty/mode registers, committed only at period boundaries for glitch-free updates.
- Supports edge-aligned and center-aligned counting.
- Sits between the register interface (software-written period/duty) and the output pads/dead-time stage.

---
 rtl/pwm_gen_multi.sv | 145 ++++++++++++++
 tb/tb_pwm_gen_multi.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_multi.sv
// Purpose : multi-channel PWM; shared period counter, per-channel compare/polarity, shadowed config committed at period boundaries.
// Latency : pwm_out is registered and lags cnt by one cycle; update_ack pulses the cycle after the commit edge.
// Backpressure: none; update_req is remembered as pending until the next boundary (or immediately while en=0).
// Ports   : clk, rst_n (async, active-low); en (global run); mode/period/duty/ch_enable (shadow inputs);
//           polarity (live); update_req/update_ack (commit handshake); cnt, dir, period_end (counter status);
//           pwm_out (registered outputs). With `define PWM_IRQ_EN: irq_clr in, irq out (sticky boundary flag).
module pwm_gen_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       ch_enable,
    input  logic [CHANNELS-1:0]       polarity,
    input  logic                      update_req,
`ifdef PWM_IRQ_EN
    input  logic                      irq_clr,
    output logic                      irq,
`endif
    output logic                      update_ack,
    output logic [WIDTH-1:0]          cnt,
    output logic                      dir,
    output logic                      period_end,
    output logic [CHANNELS-1:0]       pwm_out
);

    localparam logic             MODE_CENTER = 1'b1;
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

    // Active (committed) configuration.
    logic                mode_a;
    logic [WIDTH-1:0]    period_a;
    logic [WIDTH-1:0]    duty_a [CHANNELS];
    logic [CHANNELS-1:0] chen_a;

    logic                pending;
    logic                run_q;      // low only until the first edge after reset, keeps period_end quiet in reset
    logic                boundary;
    logic                commit;
    logic [WIDTH-1:0]    cnt_inc;
    logic [WIDTH-1:0]    cnt_nxt;
    logic                dir_nxt;
    logic [CHANNELS-1:0] raw;

    assign cnt_inc = cnt + ONE;

    always_comb begin
        boundary = 1'b0;
        if (period_a == '0)
            boundary = 1'b1;
        else if (mode_a == MODE_CENTER)
            boundary = (cnt == '0) && dir;
        else
            boundary = (cnt == period_a);
    end

    assign period_end = en && boundary && run_q;
    assign commit     = pending && (!en || boundary);

    // Free-running counter step. In center mode the state (cnt==0, dir==1) is the
    // bottom turnaround, so it is treated as the start of the up slope.
    always_comb begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        if (period_a == '0) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
        end else if (mode_a == MODE_CENTER) begin
            if (!dir || (cnt == '0)) begin
                cnt_nxt = cnt_inc;
                dir_nxt = (cnt_inc == period_a);
            end else begin
                cnt_nxt = cnt - ONE;
                dir_nxt = 1'b1;
            end
        end else begin
            cnt_nxt = boundary ? '0 : cnt_inc;
            dir_nxt = 1'b0;
        end
    end

    // On the down slope the compare also includes cnt==duty so the center-aligned
    // high time is exactly 2*duty cycles around the bottom of the triangle.
    // dir is always 0 in edge mode, so that term never fires there.
    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = en && chen_a[i] &&
                     ((cnt < duty_a[i]) ||
                      (dir && (cnt == duty_a[i]) && (duty_a[i] != '0)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_a     <= 1'b0;
            period_a   <= '0;
            chen_a     <= '0;
            for (int i = 0; i < CHANNELS; i++) duty_a[i] <= '0;
            pending    <= 1'b0;
            run_q      <= 1'b0;
            update_ack <= 1'b0;
            cnt        <= '0;
            dir        <= 1'b0;
            pwm_out    <= '0;
        end else begin
            run_q      <= 1'b1;
            // A request landing on the commit cycle is absorbed by that commit.
            pending    <= commit ? 1'b0 : (pending | update_req);
            update_ack <= commit;
            pwm_out    <= raw ^ polarity;
            if (commit) begin
                mode_a   <= mode;
                period_a <= period;
                chen_a   <= ch_enable;
                for (int i = 0; i < CHANNELS; i++) duty_a[i] <= duty[i*WIDTH +: WIDTH];
                cnt      <= '0;
                dir      <= 1'b0;
            end else if (!en) begin
                cnt      <= '0;
                dir      <= 1'b0;
            end else begin
                cnt      <= cnt_nxt;
                dir      <= dir_nxt;
            end
        end
    end

`ifdef PWM_IRQ_EN
    // Set wins over clear so a boundary is never lost to a late clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else if (en && boundary)
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_pwm_gen_multi.sv
`timescale 1ns/1ps
module tb_pwm_gen_multi;

    localparam int CH = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            mode;
    logic [W-1:0]    period;
    logic [CH*W-1:0] duty;
    logic [CH-1:0]   ch_enable;
    logic [CH-1:0]   polarity;
    logic            update_req;
    logic            update_ack;
    logic [W-1:0]    cnt;
    logic            dir;
    logic            period_end;
    logic [CH-1:0]   pwm_out;
`ifdef PWM_IRQ_EN
    logic            irq_clr;
    logic            irq;
`endif

    always #5 clk = ~clk;

    pwm_gen_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .period(period),
        .duty(duty), .ch_enable(ch_enable), .polarity(polarity),
        .update_req(update_req),
`ifdef PWM_IRQ_EN
        .irq_clr(irq_clr), .irq(irq),
`endif
        .update_ack(update_ack), .cnt(cnt), .dir(dir),
        .period_end(period_end), .pwm_out(pwm_out)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cnt;
        bit          dir;
        bit          pe;
        bit          ack;
        bit [CH-1:0] pwm;
        bit          irq;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model ----------------
    // Position within the current run (cycles since the last restart); cnt, dir and
    // boundaries are derived from it arithmetically.
    int          m_pos;
    int          m_P;
    bit          m_center;
    int          m_duty[CH];
    bit [CH-1:0] m_chen;
    bit          m_pend;
    bit          m_ack;
    bit [CH-1:0] m_pwm;
    bit          m_irq;
    bit          m_fresh;

    function automatic int m_k();
        return (m_P == 0) ? 0 : m_pos % (2 * m_P);
    endfunction

    function automatic int m_cnt();
        int k;
        if (m_P == 0) return 0;
        if (!m_center) return m_pos % (m_P + 1);
        k = m_k();
        return (k <= m_P) ? k : 2 * m_P - k;
    endfunction

    function automatic bit m_dir();
        int k;
        if (!m_center || m_P == 0) return 1'b0;
        k = m_k();
        return (k >= m_P) || (k == 0 && m_pos > 0);
    endfunction

    function automatic bit m_bnd();
        if (m_P == 0) return 1'b1;
        if (!m_center) return (m_pos % (m_P + 1)) == m_P;
        return (m_k() == 0) && (m_pos > 0);
    endfunction

    // Center mode: high window is duty cycles either side of the triangle bottom.
    function automatic bit m_high(int i);
        int d, k;
        d = m_duty[i];
        if (m_P == 0) return d > 0;
        if (!m_center) return m_cnt() < d;
        k = m_k();
        return (k < d) || (k >= 2 * m_P - d);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_P = 0; m_center = 0; m_chen = '0;
        for (int i = 0; i < CH; i++) m_duty[i] = 0;
        m_pend = 0; m_ack = 0; m_pwm = '0; m_irq = 0; m_fresh = 1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // One clock: push the expectation for the current cycle, advance the model, wait.
    task automatic step();
        exp_t e;
        bit   bnd, commit;
        bnd   = m_bnd();
        e.cnt = m_cnt();
        e.dir = m_dir();
        e.pe  = en && bnd && !m_fresh;
        e.ack = m_ack;
        e.pwm = m_pwm;
        e.irq = m_irq;
        exp_q.push_back(e);

        commit = m_pend && (!en || bnd);
        for (int i = 0; i < CH; i++) m_pwm[i] = (en && m_chen[i] && m_high(i)) ^ polarity[i];
`ifdef PWM_IRQ_EN
        if (en && bnd) m_irq = 1'b1;
        else if (irq_clr) m_irq = 1'b0;
`endif
        m_ack  = commit;
        m_pend = commit ? 1'b0 : (m_pend | update_req);
        if (commit) begin
            m_center = mode;
            m_P      = int'(period);
            m_chen   = ch_enable;
            for (int i = 0; i < CH; i++) m_duty[i] = int'(duty[i*W +: W]);
            m_pos    = 0;
        end else if (!en) begin
            m_pos = 0;
        end else begin
            m_pos++;
        end
        m_fresh = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cnt",        32'(cnt),        32'(e.cnt));
                chk("dir",        32'(dir),        32'(e.dir));
                chk("period_end", 32'(period_end), 32'(e.pe));
                chk("update_ack", 32'(update_ack), 32'(e.ack));
                chk("pwm_out",    32'(pwm_out),    32'(e.pwm));
`ifdef PWM_IRQ_EN
                chk("irq",        32'(irq),        32'(e.irq));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_duty(int i, int v);
        duty[i*W +: W] = W'(v);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic req();
        update_req = 1'b1;
        step();
        update_req = 1'b0;
    endtask

    task automatic wait_cnt(int x);
        for (int j = 0; j < 80 && m_cnt() != x; j++) step();
        chk("wait_cnt_reached", 32'(m_cnt()), 32'(x));
    endtask

    task automatic check_reset_outputs();
        chk("rst_cnt",        32'(cnt),        32'd0);
        chk("rst_dir",        32'(dir),        32'd0);
        chk("rst_period_end", 32'(period_end), 32'd0);
        chk("rst_update_ack", 32'(update_ack), 32'd0);
        chk("rst_pwm_out",    32'(pwm_out),    32'd0);
`ifdef PWM_IRQ_EN
        chk("rst_irq",        32'(irq),        32'd0);
`endif
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without waiting for an edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; period = '0; duty = '0;
        ch_enable = '0; polarity = '0; update_req = 1'b0;
`ifdef PWM_IRQ_EN
        irq_clr = 1'b0;
`endif
        model_reset();
        #3;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Edge mode, committed while disabled, then run.
        period = 16'd9; set_duty(0, 3); ch_enable = 4'b0001;
        req();
        run(3);
        en = 1'b1;
        run(30);

        // Mid-period duty change: old duty holds to the boundary.
        wait_cnt(4);
        set_duty(0, 7);
        req();
        run(25);

        // Center-aligned, duty 2 on channel 1.
        mode = 1'b1; period = 16'd8; set_duty(1, 2); ch_enable = 4'b0011;
        req();
        run(50);

        // Duty limits in edge mode, both polarities, one channel disabled.
        mode = 1'b0; period = 16'd5;
        set_duty(0, 0); set_duty(1, 6); set_duty(2, 16'hFFFF); set_duty(3, 3);
        ch_enable = 4'b0111; polarity = 4'b0000;
        req();
        run(15);
        polarity = 4'b1111;
        run(15);
        polarity = 4'b0000;

        // Zero period, both modes.
        period = 16'd0; set_duty(0, 1); ch_enable = 4'b0001;
        req();
        run(8);
        mode = 1'b1;
        req();
        run(8);

        // Reset at cnt=5 while a commit is pending.
        mode = 1'b0; period = 16'd9; set_duty(0, 3);
        req();
        run(14);
        wait_cnt(2);
        set_duty(0, 6);
        req();
        wait_cnt(5);
        async_reset();
        run(20);

`ifdef PWM_IRQ_EN
        // irq: set at boundary, clear coinciding with a boundary loses, clear alone wins.
        period = 16'd5; mode = 1'b0;
        req();
        run(10);
        for (int j = 0; j < 20 && !m_bnd(); j++) step();
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        run(2);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        run(8);
`endif

        // Randomized configurations and traffic.
        for (int it = 0; it < 40; it++) begin
            int p;
            p = $urandom_range(0, 12);
            mode = 1'($urandom_range(0, 1));
            period = W'(p);
            for (int i = 0; i < CH; i++)
                set_duty(i, ($urandom_range(0, 9) == 0) ? 16'hFFFF : $urandom_range(0, p + 2));
            ch_enable = 4'($urandom_range(0, 15));
            polarity  = 4'($urandom_range(0, 15));
            en = 1'b1;
            req();
            for (int c = 0; c < int'($urandom_range(10, 50)); c++) begin
                en = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 7) == 0) polarity = 4'($urandom_range(0, 15));
                update_req = ($urandom_range(0, 19) == 0);
                if (update_req) set_duty($urandom_range(0, CH - 1), $urandom_range(0, p + 2));
`ifdef PWM_IRQ_EN
                irq_clr = ($urandom_range(0, 5) == 0);
`endif
                step();
            end
            update_req = 1'b0;
`ifdef PWM_IRQ_EN
            irq_clr = 1'b0;
`endif
        end

        run(2);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
